// File: rtl/user_pkg.sv
// Shared constants for the user domain bus fabric.
package user_pkg;

  // Managers attached to the user domain crossbar and their indices.
  localparam int unsigned NumUserDomainManagers = 1;
  localparam int unsigned UserDmaMgr            = 0;

  // Every OBI beat from the DMA is a full 32-bit word.
  localparam logic [3:0]  ObiBeFull = 4'hF;
  localparam int unsigned WordBytes = 4;

endpackage

// File: rtl/user_dma_mgr.sv
// Single-channel word copy engine acting as an OBI manager. Copies len words from
// src to dst, one read then one write per word, never more than one transaction
// outstanding. A bus error ends the copy early and sets a sticky err_o.
module user_dma_mgr
  import user_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned LenWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] src_addr_i,
  input  logic [AddrWidth-1:0] dst_addr_i,
  input  logic [LenWidth-1:0]  len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 req_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic                 we_o,
  output logic [3:0]           be_o,
  output logic [DataWidth-1:0] wdata_o,
  input  logic                 gnt_i,
  input  logic                 rvalid_i,
  input  logic [DataWidth-1:0] rdata_i,
  input  logic                 err_i
);

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StWrWait,
    StFinish
  } state_e;

  localparam logic [AddrWidth-1:0] AddrStep = AddrWidth'(WordBytes);

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] src_q, src_d;
  logic [AddrWidth-1:0] dst_q, dst_d;
  logic [LenWidth-1:0]  cnt_q, cnt_d;
  logic [DataWidth-1:0] buf_q, buf_d;
  logic                 err_q, err_d;

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: start is only honoured in idle; responses only in the wait states.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          src_d   = src_addr_i;
          dst_d   = dst_addr_i;
          cnt_d   = len_i;
          err_d   = 1'b0;
          state_d = (len_i == '0) ? StFinish : StRdReq;
        end
      end
      StRdReq: begin
        if (gnt_i) state_d = StRdWait;
      end
      StRdWait: begin
        if (rvalid_i) begin
          if (err_i) begin
            err_d   = 1'b1;
            state_d = StFinish;
          end else begin
            buf_d   = rdata_i;
            state_d = StWrReq;
          end
        end
      end
      StWrReq: begin
        if (gnt_i) state_d = StWrWait;
      end
      StWrWait: begin
        if (rvalid_i) begin
          if (err_i) begin
            err_d   = 1'b1;
            state_d = StFinish;
          end else begin
            // Addresses wrap silently at the top of the address space.
            src_d   = src_q + AddrStep;
            dst_d   = dst_q + AddrStep;
            cnt_d   = cnt_q - LenWidth'(1);
            state_d = (cnt_q == LenWidth'(1)) ? StFinish : StRdReq;
          end
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Bus and status outputs decoded from the current state only, so they hold while stalled.
  always_comb begin
    req_o   = 1'b0;
    we_o    = 1'b0;
    addr_o  = '0;
    wdata_o = '0;
    be_o    = ObiBeFull;
    busy_o  = (state_q != StIdle);
    done_o  = (state_q == StFinish);
    err_o   = err_q;
    unique case (state_q)
      StRdReq: begin
        req_o  = 1'b1;
        addr_o = {src_q[AddrWidth-1:2], 2'b00};
      end
      StWrReq: begin
        req_o   = 1'b1;
        we_o    = 1'b1;
        addr_o  = {dst_q[AddrWidth-1:2], 2'b00};
        wdata_o = buf_q;
      end
      default: begin
        req_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_user_dma_mgr.sv
// Directed bench for user_dma_mgr: a behavioural OBI subordinate (ROM at 0x2000_0000,
// RAM at 0x1000_0000, error elsewhere) plus a scoreboard of expected bus requests.
module tb_user_dma_mgr;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [AW-1:0] src_addr_i;
  logic [AW-1:0] dst_addr_i;
  logic [LW-1:0] len_i;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic          req_o;
  logic [AW-1:0] addr_o;
  logic          we_o;
  logic [3:0]    be_o;
  logic [DW-1:0] wdata_o;
  logic          gnt_i;
  logic          rvalid_i;
  logic [DW-1:0] rdata_i;
  logic          err_i;

  always #5 clk_i = ~clk_i;

  user_dma_mgr #(
    .AddrWidth(AW),
    .DataWidth(DW),
    .LenWidth (LW)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .src_addr_i(src_addr_i),
    .dst_addr_i(dst_addr_i),
    .len_i     (len_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .req_o     (req_o),
    .addr_o    (addr_o),
    .we_o      (we_o),
    .be_o      (be_o),
    .wdata_o   (wdata_o),
    .gnt_i     (gnt_i),
    .rvalid_i  (rvalid_i),
    .rdata_i   (rdata_i),
    .err_i     (err_i)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  int          errors = 0;
  int          checks = 0;
  txn_t        exp_q[$];
  logic [31:0] ram[logic [31:0]];
  int          gnt_delay = 0;
  int          rsp_delay = 0;
  int          wr_grants = 0;

  function automatic void check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endfunction

  function automatic logic [31:0] rom_word(logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0] + 16'h1234};
  endfunction

  function automatic bit rom_hit(logic [31:0] a);
    return a[31:12] == 20'h20000;
  endfunction

  function automatic bit ram_hit(logic [31:0] a);
    return a[31:16] == 16'h1000;
  endfunction

  function automatic logic [31:0] get_ram(logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return 32'hxxxx_xxxx;
  endfunction

  // Expected R,W,R,W... sequence; stops after the first read that will error.
  function automatic void push_copy(logic [31:0] src, logic [31:0] dst, int len);
    txn_t t;
    for (int i = 0; i < len; i++) begin
      t.we = 1'b0; t.addr = src + 32'(4 * i); t.data = '0;
      exp_q.push_back(t);
      if (!rom_hit(src + 32'(4 * i))) return;
      t.we = 1'b1; t.addr = dst + 32'(4 * i); t.data = rom_word(src + 32'(4 * i));
      exp_q.push_back(t);
    end
  endfunction

  // Subordinate: grants after gnt_delay cycles, responds rsp_delay+1 cycles after grant.
  initial begin : bus
    bit          pend;
    int          pend_cnt;
    logic        pend_err;
    logic [31:0] pend_data;
    int          wait_cnt;
    bit          waiting;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic        w_we;
    bit          rst_seen;
    txn_t        t;
    gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; err_i = 1'b0;
    pend = 0; pend_cnt = 0; pend_err = 1'b0; pend_data = '0;
    wait_cnt = 0; waiting = 0; w_addr = '0; w_data = '0; w_we = 1'b0;
    forever begin
      @(posedge clk_i);
      rst_seen = !rst_ni;
      #1;
      rvalid_i = 1'b0; err_i = 1'b0; rdata_i = '0; gnt_i = 1'b0;
      if (rst_seen) begin
        pend = 0; waiting = 0; wait_cnt = 0;
      end else begin
        if (pend) begin
          if (pend_cnt == 0) begin
            rvalid_i = 1'b1; err_i = pend_err; rdata_i = pend_data; pend = 0;
          end else begin
            pend_cnt--;
          end
        end
        if (req_o) begin
          if (waiting) begin
            check("hold_addr", 64'(addr_o), 64'(w_addr));
            check("hold_we", 64'(we_o), 64'(w_we));
            check("hold_wdata", 64'(wdata_o), 64'(w_data));
          end
          if (wait_cnt >= gnt_delay) begin
            gnt_i = 1'b1; waiting = 0; wait_cnt = 0;
            check("be", 64'(be_o), 64'(4'hF));
            check("addr_lsb", 64'(addr_o[1:0]), 64'(2'b00));
            check("req_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
              t = exp_q.pop_front();
              check("req_we", 64'(we_o), 64'(t.we));
              check("req_addr", 64'(addr_o), 64'(t.addr));
              if (t.we) check("req_wdata", 64'(wdata_o), 64'(t.data));
            end
            pend = 1; pend_cnt = rsp_delay; pend_data = '0;
            if (we_o) begin
              wr_grants++;
              pend_err = !ram_hit(addr_o);
              if (ram_hit(addr_o)) ram[addr_o] = wdata_o;
            end else begin
              pend_err = !rom_hit(addr_o);
              if (rom_hit(addr_o)) pend_data = rom_word(addr_o);
            end
          end else begin
            waiting = 1; wait_cnt++;
            w_addr = addr_o; w_data = wdata_o; w_we = we_o;
          end
        end else begin
          if (waiting) check("req_held", 64'(req_o), 64'(1));
          waiting = 0; wait_cnt = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
    start_i = 1'b1; src_addr_i = src; dst_addr_i = dst; len_i = LW'(len);
    step();
    start_i = 1'b0;
  endtask

  // Watches from the cycle after start; rel=1 is the first cycle after start was sampled.
  // A stray start pulse is driven at rel==poke_rel.
  task automatic run_copy(input int poke_rel, input int bound, output int first,
                          output int done_rel, output int done_cnt, output int req_cyc);
    first = -1; done_rel = -1; done_cnt = 0; req_cyc = 0;
    for (int rel = 1; rel <= bound; rel++) begin
      if (req_o) begin
        req_cyc++;
        if (first < 0) first = rel;
      end
      if (done_o) begin
        done_cnt++;
        if (done_rel < 0) done_rel = rel;
      end
      if (done_rel >= 0 && rel >= done_rel + 4) break;
      start_i = (rel == poke_rel);
      if (rel == poke_rel) begin
        src_addr_i = 32'h2000_0800; dst_addr_i = 32'h1000_0400; len_i = LW'(2);
      end
      step();
    end
    start_i = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"}, 64'(req_o), 64'(0));
    check({tag, "_we"}, 64'(we_o), 64'(0));
    check({tag, "_busy"}, 64'(busy_o), 64'(0));
    check({tag, "_done"}, 64'(done_o), 64'(0));
    check({tag, "_err"}, 64'(err_o), 64'(0));
    check({tag, "_addr"}, 64'(addr_o), 64'(0));
    check({tag, "_wdata"}, 64'(wdata_o), 64'(0));
    check({tag, "_be"}, 64'(be_o), 64'(4'hF));
  endtask

  task automatic verify_dst(input logic [31:0] src, input logic [31:0] dst, input int len);
    for (int i = 0; i < len; i++) begin
      check("dst_word", 64'(get_ram(dst + 32'(4 * i))), 64'(rom_word(src + 32'(4 * i))));
    end
    check("queue_drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin : main
    int f, d, dc, rc;
    rst_ni = 1'b0; start_i = 1'b0; src_addr_i = '0; dst_addr_i = '0; len_i = '0;
    step();
    step();
    check_reset("reset");
    rst_ni = 1'b1;
    step();

    // Four-word copy, zero-wait grant: 4 cycles per word, done 16 cycles after first req.
    ram.delete();
    push_copy(32'h2000_0000, 32'h1000_0000, 4);
    start_copy(32'h2000_0000, 32'h1000_0000, 4);
    check("busy_after_start", 64'(busy_o), 64'(1));
    run_copy(0, 100, f, d, dc, rc);
    check("first_req_rel", 64'(f), 64'(1));
    check("done_after_first_req", 64'(d - f), 64'(16));
    check("done_count", 64'(dc), 64'(1));
    check("req_cycles", 64'(rc), 64'(8));
    check("err_clean", 64'(err_o), 64'(0));
    check("idle_busy", 64'(busy_o), 64'(0));
    verify_dst(32'h2000_0000, 32'h1000_0000, 4);

    // Same copy with every grant held off 3 cycles.
    gnt_delay = 3; ram.delete();
    push_copy(32'h2000_0000, 32'h1000_0100, 4);
    start_copy(32'h2000_0000, 32'h1000_0100, 4);
    run_copy(0, 200, f, d, dc, rc);
    check("slow_req_cycles", 64'(rc), 64'(32));
    check("slow_done_count", 64'(dc), 64'(1));
    check("slow_err", 64'(err_o), 64'(0));
    verify_dst(32'h2000_0000, 32'h1000_0100, 4);
    gnt_delay = 0;

    // Zero length: done in the cycle after start is sampled, two edges after it is driven.
    start_copy(32'h2000_0000, 32'h1000_0200, 0);
    run_copy(0, 20, f, d, dc, rc);
    check("len0_done_rel", 64'(d), 64'(1));
    check("len0_req_cycles", 64'(rc), 64'(0));
    check("len0_done_count", 64'(dc), 64'(1));

    // Read from unmapped space: error on first read, no write, one done.
    ram.delete();
    push_copy(32'h2000_3000, 32'h1000_0200, 3);
    start_copy(32'h2000_3000, 32'h1000_0200, 3);
    run_copy(0, 50, f, d, dc, rc);
    check("err_set", 64'(err_o), 64'(1));
    check("err_done_rel", 64'(d), 64'(3));
    check("err_done_count", 64'(dc), 64'(1));
    check("err_req_cycles", 64'(rc), 64'(1));
    check("err_no_write", 64'(ram.exists(32'h1000_0200)), 64'(0));
    check("err_queue", 64'(exp_q.size()), 64'(0));

    // Next start clears err_o; a second start mid-copy is ignored.
    ram.delete();
    push_copy(32'h2000_0040, 32'h1000_0300, 3);
    start_copy(32'h2000_0040, 32'h1000_0300, 3);
    check("err_cleared", 64'(err_o), 64'(0));
    run_copy(6, 100, f, d, dc, rc);
    check("poke_done_rel", 64'(d), 64'(13));
    check("poke_done_count", 64'(dc), 64'(1));
    check("poke_no_write", 64'(ram.exists(32'h1000_0400)), 64'(0));
    verify_dst(32'h2000_0040, 32'h1000_0300, 3);

    // Reset for one cycle while waiting on the second write response.
    rsp_delay = 3; wr_grants = 0; ram.delete();
    push_copy(32'h2000_0000, 32'h1000_0500, 4);
    start_copy(32'h2000_0000, 32'h1000_0500, 4);
    for (int i = 0; i < 200 && wr_grants < 2; i++) step();
    check("wr_grants_before_reset", 64'(wr_grants), 64'(2));
    step();
    rst_ni = 1'b0;
    step();
    check_reset("mid_reset");
    rst_ni = 1'b1;
    exp_q.delete();
    rsp_delay = 0;
    run_copy(0, 10, f, d, dc, rc);
    check("abandoned_done_count", 64'(dc), 64'(0));
    check("abandoned_req_cycles", 64'(rc), 64'(0));

    ram.delete();
    push_copy(32'h2000_0010, 32'h1000_0600, 2);
    start_copy(32'h2000_0010, 32'h1000_0600, 2);
    run_copy(0, 100, f, d, dc, rc);
    check("post_reset_done_rel", 64'(d), 64'(9));
    check("post_reset_done_count", 64'(dc), 64'(1));
    check("post_reset_err", 64'(err_o), 64'(0));
    verify_dst(32'h2000_0010, 32'h1000_0600, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/user_dma_mgr.md
USER_DMA_MGR -- requirements
Module: user_dma_mgr

Interface
REQ-001 SHALL have parameter AddrWidth, default 32: OBI address width.
REQ-002 SHALL have parameter DataWidth, default 32: OBI data width; one word per beat.
REQ-003 SHALL have parameter LenWidth, default 16: width of the word-count input.
REQ-004 SHALL have clk_i, input, 1: the single clock.
REQ-005 SHALL have rst_ni, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have start_i, input, 1: a one-cycle pulse that launches a copy.
REQ-007 SHALL have src_addr_i, input, AddrWidth: source byte address.
REQ-008 SHALL have dst_addr_i, input, AddrWidth: destination byte address.
REQ-009 SHALL have len_i, input, LenWidth: number of 32-bit words to copy.
REQ-010 SHALL have busy_o, output, 1: a copy is in progress.
REQ-011 SHALL have done_o, output, 1: one-cycle pulse when a copy ends, whether it succeeds or fails.
REQ-012 SHALL have err_o, output, 1: sticky bus error flag.
REQ-013 SHALL have OBI manager request outputs req_o (1), addr_o (AddrWidth), we_o (1), be_o (4), wdata_o (DataWidth).
REQ-014 SHALL have OBI manager inputs gnt_i (1), rvalid_i (1), rdata_i (DataWidth), err_i (1).

Function
REQ-015 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH.
REQ-016 In IDLE, start_i SHALL latch src, dst and len, and clear err_o.
- If len != 0, the next state SHALL be RD_REQ.
- If len == 0, the next state SHALL be FINISH, with no bus traffic.
REQ-017 start_i SHALL be ignored in every state other than IDLE, and latched values SHALL stay unchanged.
REQ-018 addr_o[1:0] SHALL be forced to 0, and be_o SHALL be 4'hF on every request.
REQ-019 RD_REQ SHALL behave as follows.
- Drive req_o=1, we_o=0, addr_o=current source address.
- Move to RD_WAIT on the cycle where gnt_i is high.
REQ-020 While req_o=1 and gnt_i=0, addr_o, we_o and wdata_o SHALL stay stable, and req_o SHALL NOT drop.
REQ-021 In RD_WAIT, req_o SHALL be 0.
- On rvalid_i with err_i=0: capture rdata_i into a one-word buffer and go to WR_REQ.
- On rvalid_i with err_i=1: set err_o and go to FINISH.
REQ-022 WR_REQ SHALL behave as follows.
- Drive req_o=1, we_o=1, addr_o=current destination address, wdata_o=buffer.
- Move to WR_WAIT on gnt_i.
REQ-023 In WR_WAIT, on rvalid_i the block SHALL act as follows.
- If err_i=1: set err_o and go to FINISH.
- Otherwise: increment src and dst by 4, and decrement the remaining count.
- If the remaining count is now 0, go to FINISH; otherwise go to RD_REQ.
REQ-024 At most one transaction SHALL be outstanding at any time.
- rvalid_i is only acted on in RD_WAIT and WR_WAIT.
- rvalid_i in any other state SHALL be ignored.
REQ-025 Address increment SHALL wrap modulo 2^AddrWidth, with no error raised.
REQ-026 FINISH SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-027 busy_o SHALL be 1 in every state except IDLE.
REQ-028 With gnt_i asserted in the same cycle and rvalid_i one cycle after grant, each word SHALL take exactly 4 cycles.
REQ-029 With the same timing, done_o SHALL rise 1 cycle after the last write response.
REQ-030 err_o SHALL hold until the next accepted start_i.
REQ-031 After an error, no further requests SHALL be issued for that copy.

Reset
REQ-032 When rst_ni=0 at a clock edge, the block SHALL reset as follows.
- FSM goes to IDLE.
- req_o, we_o, busy_o, done_o and err_o are 0.
- addr_o, wdata_o, the buffer and the counters are 0.
- be_o is 4'hF.
REQ-033 Reset during a transfer SHALL abandon the transfer immediately, including any outstanding request.
REQ-034 After reset, no done_o pulse SHALL be produced for the abandoned copy.

Structure
REQ-035 user_pkg SHALL add a manager-side constant NumUserDomainManagers = 1 and the manager index UserDmaMgr = 0.
REQ-036 The FSM state enum SHALL be local to the module, not part of the shared package.
REQ-037 The block SHALL be self-contained, with no sub-module; the one-word buffer and counters are inline registers.

Verification
REQ-038 Copy of 4 words from 0x2000_0000 (ROM) to 0x1000_0000, zero-wait grant: the bench SHALL check the following.
- 8 requests in order R,W,R,W,...
- Destination matches ROM contents.
- done_o fires 16 cycles after the first req_o, and err_o=0.
REQ-039 Same copy with gnt_i delayed 3 cycles on every request: addr_o and wdata_o stay stable while waiting, and the copy completes with correct data.
REQ-040 len_i=0: no req_o is ever asserted, and done_o pulses exactly 2 cycles after start_i.
REQ-041 Source 0x2000_3000 (unmapped, error subordinate), len 3: the bench SHALL check the following.
- The first read returns err_i=1 and err_o=1.
- No write is issued, and done_o pulses once.
- The next start_i clears err_o.
REQ-042 start_i pulsed mid-copy with different addresses: the pulse is ignored, and the original copy finishes unchanged.
REQ-043 rst_ni low for 1 cycle during WR_WAIT of word 2: the bench SHALL check the following.
- All outputs are at reset values.
- No done_o pulse occurs.
- A new copy started afterwards runs correctly.
